trigout_mux_n: RTL and testbench
================================

Name: trigout_mux_n

Overview:
- N-channel registered trigger-output selector. Routes one of N_CH trigger sources to the AFG trigger-out pin.
- Generalises the 2-input enabled trigger-out mux with a wide select and three modes:
  - level pass-through;
  - infinite edge-triggered pulse generation with programmable pulse width;
  - finite-burst pulse generation with a trigger limit.
- Sits between the waveform sequencer trigger sources and the trigger-out pad register.

Parameters:
- N_CH, 4, number of trigger source channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_CH.
- PW_W, 8, pulse-width counter width.
- CNT_W, 16, trigger counter / limit width.

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Din  in  N_CH  trigger source inputs, synchronous to Clock.
- Sel  in  SEL_W  source select index.
- EN  in  1  block enable; 0 forces output low.
- Mode  in  2  00 level, 01 infinite pulse, 10 finite burst, 11 reserved (treated as 00).
- Pulse_Width  in  PW_W  output pulse length in cycles; 0 treated as 1.
- Trig_Limit  in  CNT_W  pulses per burst in mode 10; 0 means unlimited.
- Dout  out  1  registered trigger output.
- Busy  out  1  high while a pulse is being emitted.
- Done  out  1  high in mode 10 once Trig_Limit pulses are emitted.
- Trig_Count  out  CNT_W  pulses emitted since enable; saturates at all-ones.

Behaviour:
- Reset (async, Reset_n=0):
  - Dout=0, Busy=0, Done=0, Trig_Count=0;
  - state=IDLE;
  - edge-history register (N_CH bits) = 0.
- Edge history:
  - prev[N_CH-1:0] <= Din every cycle regardless of state.
  - Rising edge on the selected source: Din[Sel] & ~prev[Sel].
  - Sel >= N_CH selects constant 0 (no edges, level output 0).
- Configuration:
  - Mode, Pulse_Width and Trig_Limit are latched on the cycle EN is sampled 0->1 (IDLE->ARMED).
  - Changes to them while EN=1 are ignored.
  - Sel is live, not latched.
- States: IDLE, ARMED, PULSE, DONE.
  - IDLE: Dout=0. EN=1 -> ARMED. On that transition, latch config and clear Trig_Count to 0.
  - ARMED, level mode: Dout <= Din[Sel] each cycle (1-cycle latency, as predecessor). Trig_Count not updated.
  - ARMED, pulse modes, rising edge detected:
    - Dout <= 1 at the same clock edge (1-cycle latency from Din rise).
    - Load width counter with max(Pulse_Width,1)-1.
    - Trig_Count +1, saturating.
    - Go to PULSE.
  - PULSE:
    - Dout=1, Busy=1.
    - Counter decrements each cycle.
    - At counter 0 the next edge drops Dout.
    - Next state: DONE if mode 10 and Trig_Limit!=0 and Trig_Count==Trig_Limit; otherwise ARMED.
    - Non-retriggerable: edges during PULSE, including its last cycle, are ignored and not counted.
  - DONE: Dout=0, Done=1. Held until EN=0.
- Output pulse is exactly max(Pulse_Width,1) cycles high. An edge on the first cycle after the pulse ends (back in ARMED) is accepted.
- EN=0 in any state: next edge forces state=IDLE and Dout=0, Busy=0, Done=0. Trig_Count is held until the next enable.
- Reset asserted mid-pulse: Dout drops asynchronously.

Optional Feature:
- Macro TRIGOUT_SYNC_EN.
- Defined: Din passes through a 2-flop synchroniser per channel before edge history and selection.
  - Input-to-Dout latency becomes 3 cycles in all modes.
  - Synchroniser flops reset to 0.
- Undefined: Din is used directly (caller guarantees synchronous sources); latency 1 cycle.

Decomposition:
- Package trigout_pkg:
  - Mode encodings (MODE_LEVEL=2'b00, MODE_PULSE=2'b01, MODE_BURST=2'b10);
  - state enum (IDLE, ARMED, PULSE, DONE);
  - helper function for saturating increment.
- One sub-module trigout_edge_det: parametrised N_CH-wide optional synchroniser plus edge-history register, outputting the synced vector and prev.

Test Plan:
- Reset with Din=4'hF, EN=1 -> Dout=0, Trig_Count=0 during reset. After release, level mode Sel=2 follows Din[2] with 1-cycle delay.
- Mode 01, Pulse_Width=3, single rise on Din[1], Sel=1 -> Dout high exactly 3 cycles starting 1 cycle after the rise, Busy matches, Trig_Count=1.
- Mode 01, Pulse_Width=4, second rise 2 cycles after first -> ignored, Trig_Count stays 1. Rise on cycle after pulse end -> new pulse, Trig_Count=2.
- Mode 10, Trig_Limit=3, Pulse_Width=1, five rises spaced 4 cycles -> exactly 3 pulses, Done=1, Trig_Count=3. EN drop -> Done=0. Re-enable -> Trig_Count=0.
- Pulse_Width=0 -> 1-cycle pulses. Sel=5 with N_CH=4 -> Dout stays 0 for any Din. EN dropped mid-pulse -> Dout=0 next edge.
- With TRIGOUT_SYNC_EN defined, repeat the level-mode test -> 3-cycle latency. Asserting Reset_n=0 mid-pulse -> Dout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trigout_pkg.sv
// -----------------------------------------------------------------------------
// trigout_pkg
// Shared types and helpers for the trigger-output selector (trigout_mux_n).
//   mode_e  : operating mode encodings (level / infinite pulse / finite burst)
//   state_e : control FSM states
//   sat_inc : saturating increment used by the trigger counter
// -----------------------------------------------------------------------------
package trigout_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_BURST = 2'b10,
        MODE_RSVD  = 2'b11   // behaves as MODE_LEVEL
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        PULSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Increment 'value' unless it already holds the all-ones pattern of a
    // 'width'-bit counter. Works for any counter width up to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/trigout_mux_n_if.sv
// -----------------------------------------------------------------------------
// trigout_mux_n_if
// Control/data bundle between the sequencer side (master) and the trigger-out
// selector (slave).
//   din         : trigger source inputs (N_CH)
//   sel         : live source select index
//   en          : block enable
//   mode        : 00 level, 01 infinite pulse, 10 finite burst, 11 level
//   pulse_width : pulse length in cycles (0 behaves as 1)
//   trig_limit  : pulses per burst (0 = unlimited)
//   dout        : registered trigger output
//   busy        : pulse in progress
//   done        : burst complete
//   trig_count  : pulses emitted since enable (saturating)
// -----------------------------------------------------------------------------
interface trigout_mux_n_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int PW_W  = 8,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]  din;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [1:0]       mode;
    logic [PW_W-1:0]  pulse_width;
    logic [CNT_W-1:0] trig_limit;
    logic             dout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] trig_count;

    modport master (
        output din, sel, en, mode, pulse_width, trig_limit,
        input  dout, busy, done, trig_count
    );

    modport slave (
        input  din, sel, en, mode, pulse_width, trig_limit,
        output dout, busy, done, trig_count
    );
endinterface

// File: rtl/trigout_edge_det.sv
// -----------------------------------------------------------------------------
// trigout_edge_det
// Optional per-channel 2-flop synchroniser followed by the edge-history
// register used for rising-edge detection.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   din     : raw trigger sources
//   sync    : synchronised sources (equal to din when not synchronising)
//   prev    : sync delayed by one cycle
// Build option: define TRIGOUT_SYNC_EN to insert the 2-flop synchroniser.
// -----------------------------------------------------------------------------
module trigout_edge_det #(
    parameter int N_CH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] sync,
    output logic [N_CH-1:0] prev
);

`ifdef TRIGOUT_SYNC_EN
    logic [N_CH-1:0] meta;
    logic [N_CH-1:0] stage2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= '0;
            stage2 <= '0;
        end else begin
            meta   <= din;
            stage2 <= meta;
        end
    end

    assign sync = stage2;
`else
    assign sync = din;
`endif

    // History is captured every cycle regardless of FSM state, so a source
    // that rose during a pulse does not produce a late edge afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

endmodule

// File: rtl/trigout_mux_n.sv
// -----------------------------------------------------------------------------
// trigout_mux_n
// N-channel registered trigger-output selector for the AFG trigger-out pin.
// Modes: level pass-through, infinite edge-triggered pulses with programmable
// width, and finite bursts limited to trig_limit pulses.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : trigout_mux_n_if.slave (din, sel, en, mode, pulse_width,
//             trig_limit in; dout, busy, done, trig_count out)
// Build option: TRIGOUT_SYNC_EN adds a 2-flop input synchroniser
// (input-to-dout latency 3 cycles instead of 1).
// -----------------------------------------------------------------------------
module trigout_mux_n
    import trigout_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int PW_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    trigout_mux_n_if.slave bus
);

    localparam int N_PAD = 1 << SEL_W;

    logic [N_CH-1:0]  sync_din;
    logic [N_CH-1:0]  prev_din;
    logic [N_PAD-1:0] cur_pad;
    logic [N_PAD-1:0] prev_pad;
    logic             cur_bit;
    logic             rise;

    state_e           state;
    mode_e            mode_q;
    logic [PW_W-1:0]  pw_q;
    logic [CNT_W-1:0] limit_q;
    logic [PW_W-1:0]  width_cnt;
    logic [CNT_W-1:0] count_q;
    logic             dout_q;
    logic             busy_q;
    logic             done_q;

    trigout_edge_det #(.N_CH(N_CH)) u_edge_det (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (bus.din),
        .sync    (sync_din),
        .prev    (prev_din)
    );

    // Zero-pad to the full select range so an index >= N_CH reads a constant
    // 0: no edges and a low level output.
    assign cur_pad  = N_PAD'(sync_din);
    assign prev_pad = N_PAD'(prev_din);
    assign cur_bit  = cur_pad[bus.sel];
    assign rise     = cur_bit & ~prev_pad[bus.sel];

    // NOTE: every register here, configuration included, sits on the async
    // reset and is updated with non-blocking assignments so all branches see
    // the pre-edge values of each other.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_q    <= MODE_LEVEL;
            pw_q      <= '0;
            limit_q   <= '0;
            width_cnt <= '0;
            count_q   <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (!bus.en) begin
            // Disable wins in every state; the count is held for readback.
            state  <= IDLE;
            dout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= ARMED;
                    mode_q  <= (bus.mode == MODE_PULSE || bus.mode == MODE_BURST)
                               ? mode_e'(bus.mode) : MODE_LEVEL;
                    pw_q    <= bus.pulse_width;
                    limit_q <= bus.trig_limit;
                    count_q <= '0;
                    dout_q  <= 1'b0;
                end

                ARMED: begin
                    if (mode_q == MODE_LEVEL) begin
                        dout_q <= cur_bit;
                    end else if (rise) begin
                        state     <= PULSE;
                        dout_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        // Counter holds remaining high cycles after this one.
                        width_cnt <= (pw_q == '0) ? '0 : pw_q - PW_W'(1);
                        count_q   <= CNT_W'(sat_inc(32'(count_q), CNT_W));
                    end
                end

                PULSE: begin
                    // Edges are ignored here: the pulse is non-retriggerable.
                    if (width_cnt == '0) begin
                        dout_q <= 1'b0;
                        busy_q <= 1'b0;
                        if (mode_q == MODE_BURST && limit_q != '0 &&
                            count_q == limit_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end else begin
                        width_cnt <= width_cnt - PW_W'(1);
                    end
                end

                DONE: begin
                    dout_q <= 1'b0;
                    done_q <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trig_count = count_q;

endmodule

// File: tb/tb_trigout_mux_n.sv
// -----------------------------------------------------------------------------
// tb_trigout_mux_n
// Self-checking bench for trigout_mux_n (N_CH=4, SEL_W=3 so that select
// values beyond the channel count can be driven). A cycle-level reference
// model, written in terms of "pulse cycles remaining" and "burst finished",
// predicts dout/busy/done/trig_count after every rising edge. Honours
// TRIGOUT_SYNC_EN by delaying the modelled input by two extra cycles.
// -----------------------------------------------------------------------------
module tb_trigout_mux_n;
    localparam int N_CH  = 4;
    localparam int SEL_W = 3;
    localparam int PW_W  = 8;
    localparam int CNT_W = 16;
`ifdef TRIGOUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clock = 1'b0;
    logic reset_n;

    trigout_mux_n_if #(.N_CH(N_CH), .SEL_W(SEL_W), .PW_W(PW_W), .CNT_W(CNT_W)) bus ();

    trigout_mux_n #(.N_CH(N_CH), .SEL_W(SEL_W), .PW_W(PW_W), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "init";

    // Reference model state
    bit       m_active;   // enabled and configured
    bit       m_done;
    bit       m_dout;
    bit       m_busy;
    int       m_mode;     // 0 level, 1 pulse, 2 burst
    int       m_pw;
    int       m_lim;
    int       m_left;     // high cycles still to come in the current pulse
    int       m_count;
    logic [3:0] m_prev;
    logic [3:0] m_pipe0;
    logic [3:0] m_pipe1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_dout = 0; m_busy = 0;
        m_mode = 0; m_pw = 0; m_lim = 0; m_left = 0; m_count = 0;
        m_prev = '0; m_pipe0 = '0; m_pipe1 = '0;
    endtask

    // Applies the rules for one rising edge using the inputs held before it.
    task automatic model_edge();
        logic [3:0] eff;
        int s;
        bit cur, prv, rise;
`ifdef TRIGOUT_SYNC_EN
        eff = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = bus.din;
`else
        eff = bus.din;
`endif
        s = int'(bus.sel);
        if (s < N_CH) begin cur = eff[s[1:0]]; prv = m_prev[s[1:0]]; end
        else begin cur = 0; prv = 0; end
        rise = cur && !prv;
        m_prev = eff;

        if (!bus.en) begin
            m_active = 0; m_dout = 0; m_busy = 0; m_done = 0; m_left = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_mode = (bus.mode == 2'd1) ? 1 : (bus.mode == 2'd2) ? 2 : 0;
            m_pw = int'(bus.pulse_width);
            m_lim = int'(bus.trig_limit);
            m_count = 0; m_dout = 0; m_left = 0;
        end else if (m_done) begin
            m_dout = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_dout = 0; m_busy = 0;
                if (m_mode == 2 && m_lim != 0 && m_count == m_lim) m_done = 1;
            end
        end else if (m_mode == 0) begin
            m_dout = cur;
        end else if (rise) begin
            m_dout = 1; m_busy = 1;
            m_left = (m_pw < 1) ? 1 : m_pw;
            m_count = (m_count >= 65535) ? m_count : m_count + 1;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!reset_n) model_reset(); else model_edge();
        #1;
        check("dout", 32'(bus.dout), 32'(m_dout));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("trig_count", 32'(bus.trig_count), 32'(m_count));
    endtask

    function automatic logic [3:0] with_bit(input int idx, input bit b);
        logic [3:0] v;
        v = 4'($urandom);
        v[idx[1:0]] = b;
        return v;
    endfunction

    task automatic reconfigure(input logic [1:0] mode, input logic [7:0] pw,
                               input logic [15:0] lim, input logic [2:0] sel);
        bus.en = 1'b0;
        cycle();
        bus.mode = mode; bus.pulse_width = pw; bus.trig_limit = lim; bus.sel = sel;
        bus.en = 1'b1;
        cycle();
    endtask

    initial begin : stim
        int lat, highs, pulses, run, max_run;
        bit last;
        bit p3 [14] = '{1,0,1,0,0,1,0,0,0,0,0,0,0,0};

        // ---- reset with sources high and enable asserted ----
        phase = "reset";
        model_reset();
        reset_n = 1'b0;
        bus.din = 4'hF; bus.en = 1'b1; bus.mode = 2'b00; bus.sel = 3'd2;
        bus.pulse_width = 8'd0; bus.trig_limit = 16'd0;
        #2;
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_count", 32'(bus.trig_count), 32'd0);
        repeat (2) cycle();
        reset_n = 1'b1;
        bus.din = 4'h0;
        repeat (4) cycle();

        // ---- level mode, sel=2: latency then random follow ----
        phase = "level";
        bus.din = 4'b0100;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (bus.dout) begin lat = i; break; end
        end
        check("level_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 16; i++) begin bus.din = 4'($urandom); cycle(); end

        // ---- infinite pulse, width 3, single rise on ch1 ----
        phase = "pulse_w3";
        bus.din = 4'h0;
        reconfigure(2'b01, 8'd3, 16'd0, 3'd1);
        bus.pulse_width = 8'd7;            // ignored while enabled
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            bus.din = with_bit(1, c >= 1 && c <= 5);
            cycle();
            highs += int'(bus.dout);
        end
        check("pulse_len", 32'(highs), 32'd3);
        check("pulse_count", 32'(bus.trig_count), 32'd1);

        // ---- width 4, retrigger ignored, rise right after pulse accepted ----
        phase = "retrig";
        bus.din = 4'h0;
        reconfigure(2'b01, 8'd4, 16'd0, 3'd1);
        pulses = 0; last = 0;
        for (int c = 0; c < 14; c++) begin
            bus.din = with_bit(1, p3[c]);
            cycle();
            if (bus.dout && !last) pulses++;
            last = bus.dout;
        end
        check("retrig_pulses", 32'(pulses), 32'd2);
        check("retrig_count", 32'(bus.trig_count), 32'd2);

        // ---- finite burst, limit 3, width 1, five rises ----
        phase = "burst";
        bus.din = 4'h0;
        reconfigure(2'b10, 8'd1, 16'd3, 3'd0);
        pulses = 0; last = 0;
        for (int c = 0; c < 24; c++) begin
            bus.din = with_bit(0, (c % 4) == 0 && c < 20);
            cycle();
            if (bus.dout && !last) pulses++;
            last = bus.dout;
        end
        check("burst_pulses", 32'(pulses), 32'd3);
        check("burst_done", 32'(bus.done), 32'd1);
        check("burst_count", 32'(bus.trig_count), 32'd3);
        bus.en = 1'b0;
        cycle();
        check("burst_done_clr", 32'(bus.done), 32'd0);
        check("burst_count_hold", 32'(bus.trig_count), 32'd3);
        bus.en = 1'b1;
        cycle();
        check("reenable_count", 32'(bus.trig_count), 32'd0);

        // ---- pulse width 0 behaves as 1 ----
        phase = "pw0";
        reconfigure(2'b01, 8'd0, 16'd0, 3'd0);
        run = 0; max_run = 0;
        for (int c = 0; c < 30; c++) begin
            bus.din = with_bit(0, (c % 3) == 0);
            cycle();
            run = bus.dout ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check("pw0_max_run", 32'(max_run), 32'd1);

        // ---- select beyond channel count ----
        phase = "sel5";
        reconfigure(2'b00, 8'd0, 16'd0, 3'd5);
        highs = 0;
        for (int c = 0; c < 15; c++) begin
            bus.din = 4'($urandom);
            cycle();
            highs += int'(bus.dout);
        end
        check("sel5_highs", 32'(highs), 32'd0);

        // ---- enable dropped mid-pulse ----
        phase = "en_drop";
        bus.din = 4'h0;
        reconfigure(2'b01, 8'd8, 16'd0, 3'd3);
        bus.din = 4'b1000;
        repeat (LAT + 2) cycle();
        check("en_drop_busy", 32'(bus.busy), 32'd1);
        bus.en = 1'b0;
        cycle();
        check("en_drop_dout", 32'(bus.dout), 32'd0);

        // ---- reset asserted mid-pulse ----
        phase = "async_rst";
        bus.din = 4'h0;
        bus.en = 1'b1;
        repeat (2) cycle();
        bus.din = 4'b1000;
        repeat (LAT + 2) cycle();
        check("pre_rst_dout", 32'(bus.dout), 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_dout", 32'(bus.dout), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        #1;
        reset_n = 1'b1;
        bus.din = 4'h0;
        repeat (3) cycle();

        // ---- randomized configurations ----
        phase = "random";
        for (int seg = 0; seg < 8; seg++) begin
            reconfigure(2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)),
                        16'($urandom_range(0, 3)), 3'($urandom_range(0, 4)));
            for (int c = 0; c < 40; c++) begin
                bus.din = 4'($urandom);
                if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
                if ($urandom_range(0, 19) == 0) bus.sel = 3'($urandom_range(0, 4));
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
